// File: rtl/wbuffer_pkg.sv
// ============================================================================
// Module   : wbuffer_pkg
// Brief    : Shared types, AXI constants and line-geometry helpers for the
//            write buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wbuffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    function automatic int line_bytes(input int line_words);
        return line_words * 4;
    endfunction

    function automatic int offset_bits(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic logic [31:0] line_align(input logic [31:0] addr, input int off);
        return addr & ~((32'h1 << off) - 32'h1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wbuffer_axi_wr.sv
// ============================================================================
// Module   : wbuffer_axi_wr
// Brief    : IDLE/AW/W/B burst engine; drains one buffer entry per burst.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wbuffer_axi_wr
    import wbuffer_pkg::*;
#(
    parameter int          LINE_WORDS = 8,
    parameter logic [3:0]  AXI_ID     = 4'd1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start_i,
    input  logic                     uncached_i,
    input  logic [31:0]              paddr_i,
    input  logic [3:0]               strb_i,
    input  logic [LINE_WORDS*32-1:0] line_i,
    output logic                     take_o,
    output logic                     done_o,
    output logic                     idle_o,
    output logic [3:0]               awid_o,
    output logic [31:0]              awaddr_o,
    output logic [3:0]               awlen_o,
    output logic [2:0]               awsize_o,
    output logic [1:0]               awburst_o,
    output logic [1:0]               awlock_o,
    output logic [3:0]               awcache_o,
    output logic [2:0]               awprot_o,
    output logic                     awvalid_o,
    input  logic                     awready_i,
    output logic [3:0]               wid_o,
    output logic [31:0]              wdata_o,
    output logic [3:0]               wstrb_o,
    output logic                     wlast_o,
    output logic                     wvalid_o,
    input  logic                     wready_i,
    input  logic                     bvalid_i,
    output logic                     bready_o
);

    localparam int                BEAT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int                OFFSET_BITS = offset_bits(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LINE_WORDS - 1);

    wb_state_e         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       words [LINE_WORDS];
    logic              last_beat;

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_words
        assign words[g] = line_i[g*32 +: 32];
    end

    // Uncached entries are a single beat carrying word 0.
    assign last_beat = uncached_i || (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        take_o    = 1'b0;
        done_o    = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        wlast_o   = 1'b0;
        bready_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    take_o  = 1'b1;
                    beat_d  = '0;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                awvalid_o = 1'b1;
                if (awready_i) state_d = ST_W;
            end
            ST_W: begin
                wvalid_o = 1'b1;
                wlast_o  = last_beat;
                if (wready_i) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign idle_o    = (state_q == ST_IDLE);
    assign awid_o    = AXI_ID;
    assign awaddr_o  = uncached_i ? paddr_i : line_align(paddr_i, OFFSET_BITS);
    assign awlen_o   = uncached_i ? 4'd0 : 4'(LINE_WORDS - 1);
    assign awsize_o  = AXI_SIZE_4B;
    assign awburst_o = AXI_BURST_INCR;
    assign awlock_o  = 2'b00;
    assign awcache_o = 4'b0000;
    assign awprot_o  = 3'b000;
    assign wid_o     = AXI_ID;
    assign wdata_o   = words[beat_q];
    assign wstrb_o   = uncached_i ? strb_i : 4'hf;

endmodule

`default_nettype wire

// File: rtl/wbuffer_param.sv
// ============================================================================
// Module   : wbuffer_param
// Brief    : FIFO write buffer between dcache and AXI write channels with
//            line coalescing and same-cycle refill lookup.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wbuffer_param
    import wbuffer_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          LINE_WORDS = 8,
    parameter logic [3:0]  AXI_ID     = 4'd1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wreq,
    input  logic                     uchd_wreq,
    input  logic [31:0]              wdata_paddr,
    input  logic [LINE_WORDS*32-1:0] wdata_line,
    input  logic [3:0]               wdata_strb,
    output logic                     wreq_recvd,
    output logic                     full,
    output logic                     empty,
    input  logic                     clear_req,
    output logic                     clear_done,
    input  logic                     lookup_req,
    input  logic [31:0]              lookup_paddr,
    output logic                     lookup_hit,
    output logic [LINE_WORDS*32-1:0] lookup_line,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [3:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [3:0]               wid,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int LINE_W      = LINE_WORDS * 32;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int LINE_BYTES  = line_bytes(LINE_WORDS);
    localparam int OFFSET_BITS = offset_bits(LINE_WORDS);

    logic              valid_q    [DEPTH];
    logic              uncached_q [DEPTH];
    logic              draining_q [DEPTH];
    logic [31:0]       paddr_q    [DEPTH];
    logic [3:0]        strb_q     [DEPTH];
    logic [LINE_W-1:0] line_q     [DEPTH];

    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              wreq_recvd_q;

    logic              coal_hit;
    logic [PTR_W-1:0]  coal_idx;
    logic [PTR_W-1:0]  lk_idx;
    logic              decide, do_coal, do_push, do_pop, take, eng_idle;
    logic              unused_bits;

    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:OFFSET_BITS] == b[31:OFFSET_BITS];
    endfunction

    // Draining entries are frozen so the burst in flight never changes.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !uncached_q[i] && !draining_q[i] &&
                same_line(paddr_q[i], wdata_paddr)) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    // Walk oldest to youngest so the youngest match is the one kept.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_line = '0;
        lk_idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PTR_W'(i);
            if (lookup_req && valid_q[lk_idx] && !uncached_q[lk_idx] &&
                same_line(paddr_q[lk_idx], lookup_paddr)) begin
                lookup_hit  = 1'b1;
                lookup_line = line_q[lk_idx];
            end
        end
    end

    // The requester still holds its request during the accept pulse.
    assign decide  = (wreq || uchd_wreq) && !clear_req && !wreq_recvd_q;
    assign do_coal = decide && wreq && coal_hit;
    assign do_push = decide && !do_coal && (count_q != CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            wreq_recvd_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]    <= 1'b0;
                draining_q[i] <= 1'b0;
            end
        end else begin
            wreq_recvd_q <= do_coal || do_push;
            count_q      <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if (do_push) begin
                valid_q[tail_q]    <= 1'b1;
                draining_q[tail_q] <= 1'b0;
                tail_q             <= tail_q + 1'b1;
            end
            if (take) draining_q[head_q] <= 1'b1;
            if (do_pop) begin
                valid_q[head_q]    <= 1'b0;
                draining_q[head_q] <= 1'b0;
                head_q             <= head_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            uncached_q[tail_q] <= uchd_wreq;
            paddr_q[tail_q]    <= wdata_paddr;
            strb_q[tail_q]     <= wdata_strb;
            line_q[tail_q]     <= wdata_line;
        end
        if (do_coal) line_q[coal_idx] <= wdata_line;
    end

    wbuffer_axi_wr #(
        .LINE_WORDS (LINE_WORDS),
        .AXI_ID     (AXI_ID)
    ) u_axi_wr (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (valid_q[head_q]),
        .uncached_i (uncached_q[head_q]),
        .paddr_i    (paddr_q[head_q]),
        .strb_i     (strb_q[head_q]),
        .line_i     (line_q[head_q]),
        .take_o     (take),
        .done_o     (do_pop),
        .idle_o     (eng_idle),
        .awid_o     (awid),
        .awaddr_o   (awaddr),
        .awlen_o    (awlen),
        .awsize_o   (awsize),
        .awburst_o  (awburst),
        .awlock_o   (awlock),
        .awcache_o  (awcache),
        .awprot_o   (awprot),
        .awvalid_o  (awvalid),
        .awready_i  (awready),
        .wid_o      (wid),
        .wdata_o    (wdata),
        .wstrb_o    (wstrb),
        .wlast_o    (wlast),
        .wvalid_o   (wvalid),
        .wready_i   (wready),
        .bvalid_i   (bvalid),
        .bready_o   (bready)
    );

    assign wreq_recvd  = wreq_recvd_q;
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0) && eng_idle;
    assign clear_done  = clear_req && empty;
    assign unused_bits = ^{bid, bresp, lookup_paddr[OFFSET_BITS-1:0], LINE_BYTES[0]};

endmodule

`default_nettype wire

// File: doc/wbuffer_param.md
Name: wbuffer_param

Overview:
- Parametrised write buffer between the data cache and the AXI write channels.
- Holds up to DEPTH pending entries in FIFO order. Each entry is either a dirty cache-line victim (LINE_WORDS words) or a single uncached word write.
- Drains entries as AXI INCR bursts in order, and coalesces repeat cached writes to the same line.
- Serves same-cycle lookups so a dcache refill can take newer data from the buffer instead of stale memory.

Parameters:
- DEPTH, 4, number of entries; power of 2, 2..16.
- LINE_WORDS, 8, 32-bit words per cache line; power of 2, 1..16 (awlen is 4 bits).
- AXI_ID, 4'd1, constant awid/wid.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low.
- wreq  in  1  cached line write request; held until wreq_recvd.
- uchd_wreq  in  1  uncached word write request; held until wreq_recvd; mutually exclusive with wreq.
- wdata_paddr  in  32  physical address (line address for cached, byte address for uncached).
- wdata_line  in  LINE_WORDS*32  line data; word 0 in bits [31:0]; uncached uses word 0 only.
- wdata_strb  in  4  byte strobe for uncached writes.
- wreq_recvd  out  1  one-cycle accept pulse.
- full  out  1  count==DEPTH.
- empty  out  1  count==0 and AXI FSM idle.
- clear_req  in  1  drain request (before sync/uncached read ordering).
- clear_done  out  1  clear_req && empty.
- lookup_req  in  1  lookup enable.
- lookup_paddr  in  32  line address to look up.
- lookup_hit  out  1  combinational hit.
- lookup_line  out  LINE_WORDS*32  data of the hit entry.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/4/3/2/2/4/3/1  AXI write address.
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data.
- wready  in  1
- bid/bresp  in  4/2  ignored.
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset: all valid bits, head/tail/count, and FSM (IDLE) cleared. wreq_recvd, awvalid, wvalid, wlast, lookup_hit and clear_done are 0; full=0; empty=1.
- Entry fields: valid, uncached, paddr, strb, line, draining.
- Acceptance:
  - The cycle wreq|uchd_wreq is seen with clear_req=0 counts as the decision cycle.
  - Coalesce case: a cached wreq whose line address (paddr[31:log2(LINE_WORDS*4)]) matches a valid, non-uncached, non-draining entry overwrites that entry's line. wreq_recvd=1 the next cycle; count unchanged.
  - Otherwise, if count<DEPTH: the request is written at tail, tail wraps modulo DEPTH, count+1, and wreq_recvd=1 the next cycle.
  - If full: no pulse; the requester keeps holding.
  - Fullness is decided on the pre-pop count, so a simultaneous pop does not admit a push that cycle.
  - Uncached requests are never coalesced.
  - clear_req=1 blocks all acceptance.
- Drain FSM, IDLE -> AW -> W -> B -> IDLE:
  - IDLE: if head is valid, mark it draining and go to AW.
  - AW:
    - awvalid=1, awsize=3'b010, awburst=2'b01, awlock=0, awcache=0, awprot=0.
    - Cached entry: awaddr = line-aligned paddr, awlen = LINE_WORDS-1.
    - Uncached entry: awaddr = paddr, awlen = 0.
    - Advance on awready.
  - W:
    - wvalid=1; a beat counter selects the word.
    - wstrb = 4'hf for cached, strb for uncached.
    - wlast on the final beat; advance on wready&&wlast.
  - B:
    - bready=1.
    - On bvalid: clear the head valid bit, head+1 modulo DEPTH, count-1, return to IDLE.
    - The pop and an acceptance may happen in the same cycle.
- Lookup:
  - lookup_hit = lookup_req && some valid cached entry (including one draining) matches the line address.
  - If several entries match (a newer one allocated after the older began draining), the youngest wins.
  - Entry data is kept until bvalid.
  - lookup_line is 0 on a miss.
- Wrap-around: head/tail are log2(DEPTH)-bit pointers; count is log2(DEPTH)+1 bits.
- Reset mid-burst: the FSM is abandoned, all entries are dropped, and AXI outputs drop the next cycle.

Decomposition:
- Shared package: FSM state encoding, AXI constants (INCR, SIZE_4B), helper localparams LINE_BYTES and OFFSET_BITS.
- Natural sub-module: wbuffer_axi_wr, the IDLE/AW/W/B burst engine that takes an entry and returns done.

Test Plan:
- DEPTH=4, LINE_WORDS=8.
  - Cached wreq at 0x0000_1040 -> wreq_recvd next cycle.
  - AW: awaddr 0x0000_1040, awlen 7.
  - 8 W beats, wlast on beat 8, wstrb 4'hf.
  - After bvalid: empty=1.
- Uncached wreq at 0x1faf_f002, strb 4'b1100 -> awlen 0, single beat with wstrb 4'b1100, wlast=1.
- Hold awready=0 and issue 5 distinct lines:
  - 4 are accepted, full=1, the 5th gets no wreq_recvd.
  - Release awready: the 5th is accepted after the first bvalid, and order is preserved.
- Two writes to line 0x2000 while the AXI side is stalled on another line:
  - count stays 2 (not 3).
  - The drained data equals the second write.
- Lookup 0x2000 while its entry is in W state -> lookup_hit=1 with the buffered data; lookup of an absent line -> hit=0 and data 0.
- clear_req with 3 entries:
  - wreq is blocked.
  - clear_done is asserted only after the 3rd bvalid.
  - Reset asserted mid-burst -> empty=1 and awvalid=wvalid=0 the next cycle.
